drs_sequencer: RTL

DRS_SEQUENCER -- requirements
Module: drs_sequencer

---
 rtl/drs_sequencer.sv | 168 ++++++++++++++++
 1 files changed

// File: rtl/drs_sequencer.sv
// DRS4 readout sequencer: reset hold, configure, start, then triggers in one of four modes.
// Optional macro DRS_SEQ_ADC_PATTERN_EN adds an incrementing ADC test pattern during RUN.
module drs_sequencer #(
  parameter int RESET_CYCLES = 127,
  parameter int CONFIG_DELAY = 127,
  parameter int START_DELAY  = 127,
  parameter int PERIOD_BITS  = 12,
  parameter int NCHAN        = 9,
  parameter int ADC_BITS     = 14
) (
  input  logic                clock,
  input  logic                reset_n,
  input  logic                enable,
  input  logic [1:0]          trig_mode,
  input  logic [7:0]          burst_len,
  input  logic                ext_trigger_i,
  input  logic                busy_i,
  input  logic [NCHAN-1:0]    chan_mask_i,
  output logic                drs_reset_o,
  output logic                configure_o,
  output logic                start_o,
  output logic                trigger_o,
  output logic [NCHAN-1:0]    trigger_chan_o,
  output logic                dropped_o,
  output logic [ADC_BITS-1:0] adc_data_o,
  output logic [15:0]         trig_count_o,
  output logic [2:0]          state_o
);
  typedef enum logic [2:0] {
    HOLD = 3'd0, CFG_WAIT = 3'd1, START_WAIT = 3'd2, RUN = 3'd3, DONE = 3'd4
  } state_t;
  typedef enum logic [1:0] {
    M_PERIODIC = 2'd0, M_ONESHOT = 2'd1, M_BURST = 2'd2, M_EXT = 2'd3
  } mode_t;

  localparam logic [15:0] HOLD_LAST  = 16'(RESET_CYCLES - 1);
  localparam logic [15:0] CFG_LAST   = 16'(CONFIG_DELAY - 1);
  localparam logic [15:0] CFG_PRE    = 16'(CONFIG_DELAY - 2);
  localparam logic [15:0] START_LAST = 16'(START_DELAY - 1);
  localparam logic [15:0] START_PRE  = 16'(START_DELAY - 2);

  state_t                 state;
  mode_t                  mode;
  logic [7:0]             blen;
  logic [7:0]             issued;
  logic [15:0]            cnt;
  logic [PERIOD_BITS-1:0] per_cnt;
  logic                   ext_prev;

  logic                   entering, finish, issue, due, fire, drop;
  mode_t                  eff_mode;
  logic [PERIOD_BITS-1:0] per_nxt;
  logic [7:0]             issued_base;

  assign state_o = state;

  // Outputs are registered, so trigger decisions are made for the cycle about to begin;
  // on the RUN entry edge the live mode/burst inputs stand in for the not-yet-loaded copies.
  always_comb begin
    entering    = (state == START_WAIT) && (cnt == START_LAST) && enable;
    eff_mode    = entering ? mode_t'(trig_mode) : mode;
    per_nxt     = entering ? '0 : per_cnt + PERIOD_BITS'(1);
    issued_base = entering ? 8'd0 : issued;
    finish      = (state == RUN) &&
                  (((mode == M_ONESHOT) && trigger_o) || ((mode == M_BURST) && (issued == blen)));
    issue       = entering || ((state == RUN) && !finish);
    case (eff_mode)
      M_PERIODIC: due = &per_nxt;
      M_ONESHOT:  due = 1'b1;
      M_BURST:    due = entering ? (burst_len != 8'd0) : (issued != blen);
      default:    due = ext_trigger_i && !ext_prev;
    endcase
    fire = issue && due && !busy_i;
    drop = issue && due && busy_i;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state          <= HOLD;
      mode           <= M_PERIODIC;
      blen           <= '0;
      issued         <= '0;
      cnt            <= '0;
      per_cnt        <= '0;
      ext_prev       <= 1'b0;
      drs_reset_o    <= 1'b1;
      configure_o    <= 1'b0;
      start_o        <= 1'b0;
      trigger_o      <= 1'b0;
      dropped_o      <= 1'b0;
      trigger_chan_o <= '0;
      trig_count_o   <= '0;
    end else begin
      ext_prev       <= ext_trigger_i;
      drs_reset_o    <= 1'b0;
      configure_o    <= 1'b0;
      start_o        <= 1'b0;
      trigger_o      <= 1'b0;
      dropped_o      <= 1'b0;
      trigger_chan_o <= '0;
      if ((state != HOLD) && !enable) begin
        state        <= HOLD;
        drs_reset_o  <= 1'b1;
        cnt          <= '0;
        per_cnt      <= '0;
        issued       <= '0;
        trig_count_o <= '0;
      end else begin
        case (state)
          HOLD: begin
            if (!enable) begin
              cnt         <= '0;
              drs_reset_o <= 1'b1;
            end else if (cnt == HOLD_LAST) begin
              state       <= CFG_WAIT;
              cnt         <= '0;
              configure_o <= (CONFIG_DELAY == 1);
            end else begin
              cnt         <= cnt + 16'd1;
              drs_reset_o <= 1'b1;
            end
          end
          CFG_WAIT: begin
            if (cnt == CFG_LAST) begin
              state   <= START_WAIT;
              cnt     <= '0;
              start_o <= (START_DELAY == 1);
            end else begin
              cnt         <= cnt + 16'd1;
              configure_o <= (cnt == CFG_PRE);
            end
          end
          START_WAIT: begin
            if (cnt == START_LAST) begin
              state <= RUN;
              cnt   <= '0;
              mode  <= mode_t'(trig_mode);
              blen  <= burst_len;
            end else begin
              cnt     <= cnt + 16'd1;
              start_o <= (cnt == START_PRE);
            end
          end
          RUN: if (finish) state <= DONE;
          default: ;
        endcase
        if (issue) begin
          per_cnt        <= per_nxt;
          issued         <= issued_base + 8'(fire);
          trigger_o      <= fire;
          dropped_o      <= drop;
          trigger_chan_o <= fire ? chan_mask_i : '0;
          if (fire && (trig_count_o != 16'hFFFF)) trig_count_o <= trig_count_o + 16'd1;
        end
      end
    end
  end

`ifdef DRS_SEQ_ADC_PATTERN_EN
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) adc_data_o <= '0;
    else if (state == RUN) adc_data_o <= adc_data_o + ADC_BITS'(1);
  end
`else
  assign adc_data_o = '0;
`endif

endmodule
